// File: rtl/fifo_rr_arbiter.sv
// fifo_rr_arbiter
//   Shares the write port of one valid/ready FIFO among NREQ producers.
//   Round-robin grant starting at ptr, 1-entry registered output stage
//   (1 beat/cycle). Each beat is tagged with the index of its source.
//
//   Optional feature macro: ARB_BURST_EN
//     defined   : the grant stays locked on a requester for up to MAXBURST
//                 consecutive beats, or until it drops valid in a load cycle.
//     undefined : pure round-robin, MAXBURST unused.
//
// Ports
//   clk_i        in   clock, rising edge
//   rstn_i       in   asynchronous active-low reset
//   req_valid_i  in   [NREQ]           per-requester valid
//   req_data_i   in   [NREQ*SIZEDATA]  requester k at [k*SIZEDATA +: SIZEDATA]
//   req_ready_o  out  [NREQ]           per-requester ready, one-hot or zero
//   valid_o      out                   beat available to the FIFO
//   data_o       out  [SIZEDATA]       beat data
//   src_o        out  [SRCW]           source requester index
//   ready_i      in                    FIFO can accept
module fifo_rr_arbiter #(
  parameter int SIZEDATA = 32,
  parameter int NREQ     = 4,
  parameter int MAXBURST = 4,
  localparam int SRCW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic [NREQ-1:0]          req_valid_i,
  input  logic [NREQ*SIZEDATA-1:0] req_data_i,
  output logic [NREQ-1:0]          req_ready_o,
  output logic                     valid_o,
  output logic [SIZEDATA-1:0]      data_o,
  output logic [SRCW-1:0]          src_o,
  input  logic                     ready_i
);

  logic [SRCW-1:0]     ptr_q, ptr_d;
  logic                valid_q, valid_d;
  logic [SIZEDATA-1:0] data_q, data_d;
  logic [SRCW-1:0]     src_q, src_d;

  logic                load_en;
  logic                gnt_any;
  logic [SRCW-1:0]     gnt_idx;
  logic [SRCW-1:0]     gnt_nxt;
  logic [SRCW:0]       scan_idx;
  logic                hs;

`ifdef ARB_BURST_EN
  localparam int CW = $clog2(MAXBURST + 1);
  logic [CW-1:0]   burst_cnt_q, burst_cnt_d;
  logic [CW-1:0]   beats;
  logic [SRCW-1:0] ptr_nxt;
`endif

  // First valid requester scanning ptr, ptr+1, ... modulo NREQ. The extra
  // bit on scan_idx holds ptr+i before the wrap so NREQ need not be 2^n.
  always_comb begin
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    scan_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      scan_idx = (SRCW+1)'(ptr_q) + (SRCW+1)'(i);
      if (scan_idx >= (SRCW+1)'(NREQ))
        scan_idx = scan_idx - (SRCW+1)'(NREQ);
      if (!gnt_any && req_valid_i[scan_idx[SRCW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = scan_idx[SRCW-1:0];
      end
    end
  end

  assign load_en = !valid_q || ready_i;
  assign hs      = load_en && gnt_any;
  assign gnt_nxt = (gnt_idx == SRCW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;

  // Gated with rstn_i so ready stays low for the whole reset, even though
  // the emptied output stage would otherwise enable a load.
  assign req_ready_o = (hs && rstn_i) ? (NREQ'(1) << gnt_idx) : '0;

  always_comb begin
    ptr_d   = ptr_q;
    valid_d = valid_q;
    data_d  = data_q;
    src_d   = src_q;
`ifdef ARB_BURST_EN
    burst_cnt_d = burst_cnt_q;
    beats       = '0;
    ptr_nxt     = (ptr_q == SRCW'(NREQ-1)) ? '0 : ptr_q + 1'b1;
`endif
    if (hs) begin
      valid_d = 1'b1;
      data_d  = req_data_i[int'(gnt_idx)*SIZEDATA +: SIZEDATA];
      src_d   = gnt_idx;
`ifdef ARB_BURST_EN
      // A nonzero count means ptr holds the locked owner; a grant to anyone
      // else means the owner dropped valid, so a fresh burst starts.
      beats = (burst_cnt_q != '0 && gnt_idx == ptr_q) ? burst_cnt_q + 1'b1
                                                        : CW'(1);
      if (beats < CW'(MAXBURST)) begin
        ptr_d       = gnt_idx;
        burst_cnt_d = beats;
      end else begin
        ptr_d       = gnt_nxt;
        burst_cnt_d = '0;
      end
`else
      ptr_d = gnt_nxt;
`endif
    end else if (load_en) begin
      // Drained (or still empty) with nothing to load; data/src hold.
      valid_d = 1'b0;
`ifdef ARB_BURST_EN
      // Locked owner idle in a load cycle: lock ends.
      if (burst_cnt_q != '0) begin
        ptr_d       = ptr_nxt;
        burst_cnt_d = '0;
      end
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ptr_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      src_q   <= '0;
    end else begin
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      src_q   <= src_d;
    end
  end

`ifdef ARB_BURST_EN
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) burst_cnt_q <= '0;
    else         burst_cnt_q <= burst_cnt_d;
  end
`endif

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign src_o   = src_q;

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
module tb_fifo_rr_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int MB = 4;

  logic              clk;
  logic              rstn;
  logic [N-1:0]      req_valid;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      req_ready;
  logic              valid_o;
  logic [DW-1:0]     data_o;
  logic [1:0]        src_o;
  logic              ready_i;

  int n_vec = 0;
  int n_err = 0;

  fifo_rr_arbiter #(.SIZEDATA(DW), .NREQ(N), .MAXBURST(MB)) dut (
    .clk_i(clk), .rstn_i(rstn), .req_valid_i(req_valid), .req_data_i(req_data),
    .req_ready_o(req_ready), .valid_o(valid_o), .data_o(data_o), .src_o(src_o),
    .ready_i(ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural reference: beats carry (data, source); ptr is the first index
  // to look at; m_cnt counts beats of the current burst (burst build only).
  int              m_ptr, m_cnt;
  logic            m_valid;
  logic [DW-1:0]   m_data;
  int              m_src;

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int i = 0; i < N; i++)
      if (v[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  function automatic logic [DW-1:0] slice(input logic [N*DW-1:0] d, input int k);
    return d[k*DW +: DW];
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_cnt = 0; m_valid = 1'b0; m_data = '0; m_src = 0;
  endtask

  // Grant the model would give this cycle (-1 = none).
  function automatic int model_grant();
    if (m_valid && !ready_i) return -1;
    return pick(req_valid, m_ptr);
  endfunction

  task automatic model_clock();
    int g;
    int n;
    g = model_grant();
    if (g >= 0) begin
      m_valid = 1'b1; m_data = slice(req_data, g); m_src = g;
`ifdef ARB_BURST_EN
      n = (m_cnt > 0 && g == m_ptr) ? m_cnt + 1 : 1;
      if (n < MB) begin m_ptr = g; m_cnt = n; end
      else begin m_ptr = (g + 1) % N; m_cnt = 0; end
`else
      n = 0;
      m_ptr = (g + 1) % N;
`endif
    end else if (!m_valid || ready_i) begin
      m_valid = 1'b0;
`ifdef ARB_BURST_EN
      if (m_cnt > 0) begin m_ptr = (m_ptr + 1) % N; m_cnt = 0; end
`endif
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0; req_valid = '0; ready_i = 1'b1;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    model_reset();
  endtask

  // One model-checked cycle: inputs already driven just after a negedge.
  task automatic model_step(input string tag);
    int g;
    #1;
    g = model_grant();
    chk({tag, " ready"}, 32'(req_ready), (g >= 0) ? 32'(1 << g) : 32'd0);
    model_clock();
    @(posedge clk); #1;
    chk({tag, " valid"}, 32'(valid_o), 32'(m_valid));
    chk({tag, " src"},   32'(src_o),   32'(m_src));
    chk({tag, " data"},  data_o,       m_data);
  endtask

  typedef struct {
    logic [N-1:0] v;
    logic         rdy;
    logic [N-1:0] e_rdy;
    logic         e_vld;
    logic [1:0]   e_src;
  } vec_t;

  vec_t tbl[13];

  initial begin
    rstn = 1'b0; req_valid = '0; req_data = '0; ready_i = 1'b0;
    #2;
    chk("reset valid", 32'(valid_o), 32'd0);
    chk("reset src",   32'(src_o),   32'd0);
    chk("reset data",  data_o,       32'd0);
    chk("reset ready", 32'(req_ready), 32'd0);
    do_reset();

    for (int k = 0; k < N; k++) req_data[k*DW +: DW] = 32'hA5A5_0000 | 32'(k);

`ifndef ARB_BURST_EN
    // Single req 2, back-to-back; all valid from ptr 3; backpressure x3;
    // sparse {1,3} from ptr 2; idle.
    tbl[0]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2};
    tbl[1]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2};
    tbl[2]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3};
    tbl[3]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
    tbl[4]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0};
    tbl[5]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0};
    tbl[6]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0};
    tbl[7]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};
    tbl[8]  = '{4'b1010, 1'b1, 4'b1000, 1'b1, 2'd3};
    tbl[9]  = '{4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1};
    tbl[10] = '{4'b1010, 1'b1, 4'b1000, 1'b1, 2'd3};
    tbl[11] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3};
    tbl[12] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd3};
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      req_valid = tbl[i].v; ready_i = tbl[i].rdy;
      #1;
      chk($sformatf("tbl%0d ready", i), 32'(req_ready), 32'(tbl[i].e_rdy));
      @(posedge clk); #1;
      chk($sformatf("tbl%0d valid", i), 32'(valid_o), 32'(tbl[i].e_vld));
      chk($sformatf("tbl%0d src", i),   32'(src_o),   32'(tbl[i].e_src));
      chk($sformatf("tbl%0d data", i),  data_o,       32'hA5A5_0000 | 32'(tbl[i].e_src));
    end
`endif

    // All valid, ready high: order 0,1,2,3,... (runs of MB in burst build).
    do_reset();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      req_valid = '1; ready_i = 1'b1;
      @(posedge clk); #1;
`ifdef ARB_BURST_EN
      chk($sformatf("allv%0d src", i), 32'(src_o), 32'((i / MB) % N));
`else
      chk($sformatf("allv%0d src", i), 32'(src_o), 32'(i % N));
`endif
      chk($sformatf("allv%0d valid", i), 32'(valid_o), 32'd1);
    end

`ifdef ARB_BURST_EN
    // Req 0 drops valid after 2 beats: grant moves to req 1.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req_valid = (i < 2) ? 4'b1111 : 4'b1110; ready_i = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("drop%0d src", i), 32'(src_o), (i < 2) ? 32'd0 : 32'd1);
    end
`endif

    // Asynchronous reset mid-beat, with valid_o held by backpressure.
    @(negedge clk);
    req_valid = '1; ready_i = 1'b0;
    @(posedge clk); #1;
    chk("pre-rst valid", 32'(valid_o), 32'd1);
    #2 rstn = 1'b0;
    #1;
    chk("async rst valid", 32'(valid_o), 32'd0);
    chk("async rst ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rstn = 1'b1; ready_i = 1'b1;
    #1;
    chk("post-rst ready", 32'(req_ready), 32'b0001);
    @(posedge clk); #1;
    chk("post-rst src", 32'(src_o), 32'd0);

    // Randomized traffic against the reference model.
    do_reset();
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      req_valid = N'($urandom);
      if ($urandom_range(0, 3) == 0) req_valid = '1;
      for (int k = 0; k < N; k++) req_data[k*DW +: DW] = $urandom;
      ready_i = ($urandom_range(0, 3) != 0);
      model_step($sformatf("rnd%0d", c));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end
endmodule
